// File: rtl/kv_lookup_mux_if.sv
// Bus bundle for kv_lookup_mux: per-channel key inputs, the hash-table lookup
// request/response pair, per-channel responses and the status outputs.
// Handshake rule for every valid/ready pair here: a beat transfers on a rising
// edge where valid and ready are both high; a source that raises valid keeps
// valid and data stable until that transfer occurs.
interface kv_lookup_mux_if #(
  parameter int NUM_CH    = 2,
  parameter int KEY_WIDTH = 64,
  parameter int LUP_WIDTH = 96,
  parameter int RSP_WIDTH = 120,
  parameter int TAG_DEPTH = 16
);
  logic [NUM_CH-1:0]             s_key_valid;
  logic [NUM_CH*KEY_WIDTH-1:0]   s_key_data;
  logic [NUM_CH-1:0]             s_key_ready;

  logic                          m_lup_req_valid;
  logic                          m_lup_req_ready;
  logic [LUP_WIDTH-1:0]          m_lup_req_data;

  logic                          s_lup_rsp_valid;
  logic                          s_lup_rsp_ready;
  logic [RSP_WIDTH-1:0]          s_lup_rsp_data;

  logic [NUM_CH-1:0]             m_rsp_valid;
  logic [NUM_CH-1:0]             m_rsp_ready;
  logic [NUM_CH*RSP_WIDTH-1:0]   m_rsp_data;

  logic [$clog2(TAG_DEPTH):0]    outstanding;
  logic                          rsp_orphan;

  modport master (
    input  s_key_valid, s_key_data,
    output s_key_ready,
    output m_lup_req_valid, m_lup_req_data,
    input  m_lup_req_ready,
    input  s_lup_rsp_valid, s_lup_rsp_data,
    output s_lup_rsp_ready,
    output m_rsp_valid, m_rsp_data,
    input  m_rsp_ready,
    output outstanding, rsp_orphan
  );

  modport slave (
    output s_key_valid, s_key_data,
    input  s_key_ready,
    input  m_lup_req_valid, m_lup_req_data,
    output m_lup_req_ready,
    output s_lup_rsp_valid, s_lup_rsp_data,
    input  s_lup_rsp_ready,
    input  m_rsp_valid, m_rsp_data,
    output m_rsp_ready,
    input  outstanding, rsp_orphan
  );
endinterface

// File: rtl/kv_lookup_mux.sv
// Round-robin multiplexer of per-channel key lookups onto one hash-table port;
// a tag FIFO of granted channel indices routes in-order responses back.
module kv_lookup_mux #(
  parameter int NUM_CH    = 2,
  parameter int KEY_WIDTH = 64,
  parameter int LUP_WIDTH = 96,
  parameter int RSP_WIDTH = 120,
  parameter int TAG_DEPTH = 16
) (
  input logic             axis_clk,
  input logic             axis_rst,
  kv_lookup_mux_if.master bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [CH_W-1:0]      last_grant;
  logic [CH_W-1:0]      grant;
  logic                 grant_found;
  logic [KEY_WIDTH-1:0] grant_key;

  logic [CH_W-1:0]      tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CH_W-1:0]      head;
  logic                 head_ready;

  logic                 req_valid_q;
  logic [LUP_WIDTH-1:0] req_data_q;
  logic                 orphan_q;

  logic fifo_full, fifo_empty, load, pop, orphan_hit;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  // Round-robin: channels above last_grant first, then wrap to the lower ones.
  always_comb begin
    grant       = last_grant;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && bus.s_key_valid[i] && (CH_W'(i) > last_grant)) begin
        grant       = CH_W'(i);
        grant_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && bus.s_key_valid[i] && (CH_W'(i) <= last_grant)) begin
        grant       = CH_W'(i);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_key  = '0;
    head_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) grant_key = bus.s_key_data[i*KEY_WIDTH +: KEY_WIDTH];
      if (head == CH_W'(i))  head_ready = bus.m_rsp_ready[i];
    end
  end

  // A full FIFO blocks the load even when a pop happens in the same cycle.
  assign load = !axis_rst && (!req_valid_q || bus.m_lup_req_ready) &&
                grant_found && !fifo_full;
  assign pop        = !axis_rst && !fifo_empty && bus.s_lup_rsp_valid && head_ready;
  assign orphan_hit = !axis_rst && fifo_empty && bus.s_lup_rsp_valid;

  always_comb begin
    bus.s_key_ready     = '0;
    bus.m_rsp_valid     = '0;
    bus.s_lup_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.s_key_ready[i] = load && (grant == CH_W'(i));
    end
    if (!axis_rst) begin
      if (fifo_empty) begin
        bus.s_lup_rsp_ready = 1'b1;
      end else begin
        bus.s_lup_rsp_ready = head_ready;
        for (int i = 0; i < NUM_CH; i++) begin
          bus.m_rsp_valid[i] = bus.s_lup_rsp_valid && (head == CH_W'(i));
        end
      end
    end
  end

  assign bus.m_rsp_data      = {NUM_CH{bus.s_lup_rsp_data}};
  assign bus.m_lup_req_valid = req_valid_q;
  assign bus.m_lup_req_data  = req_data_q;
  assign bus.outstanding     = count;
  assign bus.rsp_orphan      = orphan_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      orphan_q    <= 1'b0;
    end else begin
      orphan_q <= orphan_hit;
      if (load) begin
        req_valid_q <= 1'b1;
        req_data_q  <= LUP_WIDTH'(grant_key);
        last_grant  <= grant;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end else if (bus.m_lup_req_ready) begin
        req_valid_q <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({load, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge axis_clk) begin
    if (load) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_kv_lookup_mux.sv
// Bench for kv_lookup_mux: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the lookup multiplexer.
module tb_kv_lookup_mux;
  localparam int NUM_CH    = 2;
  localparam int KEY_WIDTH = 64;
  localparam int LUP_WIDTH = 96;
  localparam int RSP_WIDTH = 120;
  localparam int TAG_DEPTH = 4;

  logic axis_clk = 1'b0;
  logic axis_rst;

  int n_tests = 0;
  int n_fail  = 0;

  kv_lookup_mux_if #(
    .NUM_CH(NUM_CH), .KEY_WIDTH(KEY_WIDTH), .LUP_WIDTH(LUP_WIDTH),
    .RSP_WIDTH(RSP_WIDTH), .TAG_DEPTH(TAG_DEPTH)
  ) bus ();

  kv_lookup_mux #(
    .NUM_CH(NUM_CH), .KEY_WIDTH(KEY_WIDTH), .LUP_WIDTH(LUP_WIDTH),
    .RSP_WIDTH(RSP_WIDTH), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .axis_clk(axis_clk),
    .axis_rst(axis_rst),
    .bus(bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 axis_clk = ~axis_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model state ----------------
  bit                   mdl_known = 1'b0;
  bit                   mdl_req_valid;
  logic [LUP_WIDTH-1:0] mdl_req_data;
  int                   mdl_last;
  int                   mdl_tags[$];
  bit                   mdl_orphan;

  logic [NUM_CH-1:0] seen_kready;
  logic [NUM_CH-1:0] seen_rvalid;
  logic              seen_lready;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: inputs are already applied (at the falling edge).
  task automatic step();
    logic [NUM_CH-1:0] e_kready;
    logic [NUM_CH-1:0] e_rvalid;
    logic              e_lready;
    bit ld, pop;
    int g, head, sz;
    #1;
    if (mdl_known) begin
      check("req_valid", bus.m_lup_req_valid, mdl_req_valid);
      check("req_data", bus.m_lup_req_data, mdl_req_data);
      check("outstanding", bus.outstanding, mdl_tags.size());
      check("rsp_orphan", bus.rsp_orphan, mdl_orphan);
    end
    e_kready = '0; e_rvalid = '0; e_lready = 1'b0;
    ld = 0; pop = 0; g = 0; head = 0;
    sz = mdl_tags.size();
    if (!axis_rst) begin
      ld = (!mdl_req_valid || bus.m_lup_req_ready) && (bus.s_key_valid != '0) && (sz < TAG_DEPTH);
      if (ld) begin
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
          int c;
          c = (mdl_last + k) % NUM_CH;
          if (g < 0 && bus.s_key_valid[c]) g = c;
        end
        e_kready[g] = 1'b1;
      end
      if (sz > 0) begin
        head = mdl_tags[0];
        e_rvalid[head] = bus.s_lup_rsp_valid;
        e_lready = bus.m_rsp_ready[head];
        pop = bus.s_lup_rsp_valid && e_lready;
      end else begin
        e_lready = 1'b1;
      end
    end
    check("s_key_ready", bus.s_key_ready, e_kready);
    check("m_rsp_valid", bus.m_rsp_valid, e_rvalid);
    check("s_lup_rsp_ready", bus.s_lup_rsp_ready, e_lready);
    check("m_rsp_data", bus.m_rsp_data, {NUM_CH{bus.s_lup_rsp_data}});
    seen_kready = bus.s_key_ready;
    seen_rvalid = bus.m_rsp_valid;
    seen_lready = bus.s_lup_rsp_ready;
    @(posedge axis_clk);
    if (axis_rst) begin
      mdl_req_valid = 1'b0;
      mdl_req_data  = '0;
      mdl_last      = NUM_CH - 1;
      mdl_tags.delete();
      mdl_orphan    = 1'b0;
      mdl_known     = 1'b1;
    end else begin
      mdl_orphan = (sz == 0) && bus.s_lup_rsp_valid;
      if (pop) void'(mdl_tags.pop_front());
      if (ld) begin
        mdl_tags.push_back(g);
        mdl_last = g;
        mdl_req_valid = 1'b1;
        mdl_req_data = '0;
        mdl_req_data[KEY_WIDTH-1:0] = bus.s_key_data[g*KEY_WIDTH +: KEY_WIDTH];
      end else if (bus.m_lup_req_ready) begin
        mdl_req_valid = 1'b0;
      end
    end
    @(negedge axis_clk);
  endtask

  task automatic set_key(input int ch, input logic [KEY_WIDTH-1:0] key);
    bus.s_key_data[ch*KEY_WIDTH +: KEY_WIDTH] = key;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    axis_rst            = 1'b1;
    bus.s_key_valid     = '0;
    bus.s_key_data      = '0;
    bus.m_lup_req_ready = 1'b0;
    bus.s_lup_rsp_valid = 1'b0;
    bus.s_lup_rsp_data  = '0;
    bus.m_rsp_ready     = '0;
    @(negedge axis_clk);
    step();
    step();
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_req_valid", bus.m_lup_req_valid, 0);
    check("rst_req_data", bus.m_lup_req_data, 0);
    check("rst_orphan", bus.rsp_orphan, 0);

    // Fairness with both channels always valid, then full-FIFO blocking.
    axis_rst = 1'b0;
    set_key(0, 64'h1111_2222_3333_4444);
    set_key(1, 64'h5555_6666_7777_8888);
    bus.s_key_valid     = 2'b11;
    bus.m_lup_req_ready = 1'b1;
    bus.m_rsp_ready     = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair_grant", seen_kready, (i % 2) ? 2'b10 : 2'b01);
      if (i == 0) begin
        check("first_req_valid", bus.m_lup_req_valid, 1);
        check("first_req_data", bus.m_lup_req_data, 96'h0000_0000_1111_2222_3333_4444);
      end
    end
    check("full_outstanding", bus.outstanding, 4);
    bus.s_lup_rsp_valid = 1'b1;
    bus.s_lup_rsp_data  = 120'hAB_CDEF;
    step();
    check("full_pop_no_load", seen_kready, 2'b00);
    check("full_pop_ready", seen_lready, 1);
    bus.s_lup_rsp_valid = 1'b0;
    step();
    check("after_pop_load", seen_kready, 2'b01);
    bus.s_key_valid     = 2'b00;
    bus.s_lup_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.s_lup_rsp_valid = 1'b0;
    check("drained", bus.outstanding, 0);

    // Zero extension and hold under backpressure.
    set_key(1, 64'hDEAD_BEEF_0123_4567);
    bus.s_key_valid     = 2'b10;
    bus.m_lup_req_ready = 1'b0;
    step();
    bus.s_key_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("ze_valid", bus.m_lup_req_valid, 1);
      check("ze_data", bus.m_lup_req_data, 96'h0000_0000_DEAD_BEEF_0123_4567);
      step();
    end
    bus.m_lup_req_ready = 1'b1;
    step();
    bus.s_lup_rsp_valid = 1'b1;
    step();
    bus.s_lup_rsp_valid = 1'b0;

    // In-order routing ch1, ch0, ch1 with a stall on ch1.
    bus.s_key_valid = 2'b10; step();
    bus.s_key_valid = 2'b01; step();
    bus.s_key_valid = 2'b10; step();
    bus.s_key_valid = 2'b00;
    check("route_outstanding", bus.outstanding, 3);
    bus.s_lup_rsp_valid = 1'b1;
    bus.m_rsp_ready     = 2'b01;
    for (int i = 0; i < 2; i++) begin
      bus.s_lup_rsp_data = RSP_WIDTH'({$urandom, $urandom, $urandom, $urandom});
      step();
      check("stall_valid", seen_rvalid, 2'b10);
      check("stall_ready", seen_lready, 0);
    end
    bus.m_rsp_ready = 2'b11;
    step(); check("route_0", seen_rvalid, 2'b10);
    step(); check("route_1", seen_rvalid, 2'b01);
    step(); check("route_2", seen_rvalid, 2'b10);
    bus.s_lup_rsp_valid = 1'b0;
    step();

    // Orphan response with nothing outstanding.
    bus.s_lup_rsp_valid = 1'b1;
    step();
    check("orphan_ready", seen_lready, 1);
    check("orphan_no_valid", seen_rvalid, 2'b00);
    check("orphan_pulse", bus.rsp_orphan, 1);
    bus.s_lup_rsp_valid = 1'b0;
    step();
    check("orphan_clear", bus.rsp_orphan, 0);

    // Reset with three tags outstanding.
    bus.s_key_valid = 2'b01;
    for (int i = 0; i < 3; i++) step();
    bus.s_key_valid = 2'b00;
    check("mid_outstanding", bus.outstanding, 3);
    axis_rst = 1'b1;
    bus.s_key_valid = 2'b11;
    step();
    check("rst_kready", seen_kready, 2'b00);
    check("rst_lready", seen_lready, 0);
    check("rst_cleared", bus.outstanding, 0);
    axis_rst = 1'b0;
    bus.s_key_valid = 2'b00;
    bus.s_lup_rsp_valid = 1'b1;
    step();
    check("rst_orphan_pulse", bus.rsp_orphan, 1);
    bus.s_lup_rsp_valid = 1'b0;
    step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      axis_rst            = ($urandom_range(0, 199) == 0);
      bus.s_key_valid     = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) set_key(c, {$urandom, $urandom});
      bus.m_lup_req_ready = ($urandom_range(0, 3) != 0);
      bus.s_lup_rsp_valid = ($urandom_range(0, 2) != 0);
      bus.s_lup_rsp_data  = RSP_WIDTH'({$urandom, $urandom, $urandom, $urandom});
      bus.m_rsp_ready     = NUM_CH'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
